// File: rtl/icache_controller.sv
// Sequencing controller for one direct-mapped instruction-cache set.
// Optional hit/miss statistics counters: define ICACHE_CTRL_STATS_EN.
module icache_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int SIZE       = 128
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_flush,
    output logic                  o_ack,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_busy,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_rd,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    input  logic                  i_mem_ack,
    output logic [ADDR_WIDTH-1:0] o_set_addr,
    output logic                  o_set_wr,
    output logic                  o_set_cl,
    output logic [DATA_WIDTH-1:0] o_set_data,
    input  logic [DATA_WIDTH-1:0] i_set_data,
    input  logic                  i_set_hit
`ifdef ICACHE_CTRL_STATS_EN
    ,
    output logic [31:0]           o_hit_count,
    output logic [31:0]           o_miss_count
`endif
);

    localparam int INDEX_WIDTH = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic [2:0] {INIT, IDLE, LOOKUP, FILL, WRITE, RESPOND} state_t;

    state_t                  state_q, state_d;
    logic [INDEX_WIDTH-1:0]  idx_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   fill_q;
    logic [DATA_WIDTH-1:0]   data_q;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= INIT;
            idx_q   <= '0;
            addr_q  <= '0;
            fill_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT)
                idx_q <= idx_q + 1'b1;
            else if (state_q == IDLE && i_flush)
                idx_q <= '0;
            if (state_q == IDLE && !i_flush && i_req)
                addr_q <= i_addr;
            if (state_q == FILL && i_mem_ack)
                fill_q <= i_mem_data;
            // Keep the last returned word visible between acknowledgements.
            if (o_ack)
                data_q <= o_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        o_ack      = 1'b0;
        o_data     = data_q;
        o_mem_rd   = 1'b0;
        o_set_wr   = 1'b0;
        o_set_cl   = 1'b0;
        o_set_addr = addr_q;
        case (state_q)
            INIT: begin
                o_set_cl   = 1'b1;
                o_set_addr = ADDR_WIDTH'(idx_q);
                if (idx_q == INDEX_WIDTH'(SIZE - 1))
                    state_d = IDLE;
            end
            IDLE: begin
                // Present the incoming address now so the set read overlaps the request cycle.
                o_set_addr = i_addr;
                if (i_flush)
                    state_d = INIT;
                else if (i_req)
                    state_d = LOOKUP;
            end
            LOOKUP: begin
                if (i_set_hit) begin
                    o_ack   = 1'b1;
                    o_data  = i_set_data;
                    state_d = IDLE;
                end else begin
                    state_d = FILL;
                end
            end
            FILL: begin
                o_mem_rd = 1'b1;
                if (i_mem_ack)
                    state_d = WRITE;
            end
            WRITE: begin
                o_set_wr = 1'b1;
                state_d  = RESPOND;
            end
            RESPOND: begin
                o_ack   = 1'b1;
                o_data  = fill_q;
                state_d = IDLE;
            end
            default: state_d = INIT;
        endcase
    end

    assign o_busy     = (state_q != IDLE);
    assign o_mem_addr = addr_q;
    assign o_set_data = fill_q;

`ifdef ICACHE_CTRL_STATS_EN
    logic [31:0] hit_q, miss_q;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (state_q == IDLE && i_flush) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (state_q == LOOKUP) begin
            if (i_set_hit) begin
                if (hit_q != '1)
                    hit_q <= hit_q + 32'd1;
            end else begin
                if (miss_q != '1)
                    miss_q <= miss_q + 32'd1;
            end
        end
    end

    assign o_hit_count  = hit_q;
    assign o_miss_count = miss_q;
`endif

endmodule

// File: tb/tb_icache_controller.sv
// Self-checking bench for icache_controller (SIZE=8) with behavioural set, memory and
// cache reference models; stats checks compile in when ICACHE_CTRL_STATS_EN is defined.
module tb_icache_controller;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SZ = 8;

    logic          clk;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_flush;
    logic          o_ack;
    logic [DW-1:0] o_data;
    logic          o_busy;
    logic [AW-1:0] o_mem_addr;
    logic          o_mem_rd;
    logic [DW-1:0] i_mem_data;
    logic          i_mem_ack;
    logic [AW-1:0] o_set_addr;
    logic          o_set_wr;
    logic          o_set_cl;
    logic [DW-1:0] o_set_data;
    logic [DW-1:0] i_set_data;
    logic          i_set_hit;
`ifdef ICACHE_CTRL_STATS_EN
    logic [31:0]   o_hit_count;
    logic [31:0]   o_miss_count;
`endif

    int vectors;
    int miscompares;

    icache_controller #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .SIZE       (SZ)
    ) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_flush    (i_flush),
        .o_ack      (o_ack),
        .o_data     (o_data),
        .o_busy     (o_busy),
        .o_mem_addr (o_mem_addr),
        .o_mem_rd   (o_mem_rd),
        .i_mem_data (i_mem_data),
        .i_mem_ack  (i_mem_ack),
        .o_set_addr (o_set_addr),
        .o_set_wr   (o_set_wr),
        .o_set_cl   (o_set_cl),
        .o_set_data (o_set_data),
        .i_set_data (i_set_data),
        .i_set_hit  (i_set_hit)
`ifdef ICACHE_CTRL_STATS_EN
        ,
        .o_hit_count  (o_hit_count),
        .o_miss_count (o_miss_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Backing memory: acks on the mem_lat-th cycle of a read, returns mem_value.
    int            mem_lat;
    logic [DW-1:0] mem_value;
    int            mem_cnt;

    initial begin
        mem_cnt    = 0;
        i_mem_ack  = 1'b0;
        i_mem_data = '0;
        forever begin
            @(posedge clk); #1;
            if (o_mem_rd === 1'b1) begin
                mem_cnt++;
                if (mem_cnt == mem_lat) begin
                    i_mem_ack  = 1'b1;
                    i_mem_data = mem_value;
                end else begin
                    i_mem_ack  = 1'b0;
                    i_mem_data = $urandom;
                end
            end else begin
                mem_cnt    = 0;
                i_mem_ack  = 1'b0;
                i_mem_data = $urandom;
            end
        end
    end

    // Cache set storage: synchronous read, one cycle after the address.
    logic [AW-1:0] s_tag   [SZ];
    logic [DW-1:0] s_data  [SZ];
    logic          s_valid [SZ];
    logic [AW-1:0] c_addr;
    logic          c_wr, c_cl;
    logic [DW-1:0] c_wdata;
    int            c_idx;

    initial begin
        for (int i = 0; i < SZ; i++) begin
            s_valid[i] = 1'b1;          // stale entries the sweep must clear
            s_tag[i]   = '0;
            s_data[i]  = 32'hBAD0_0000 + 32'(i);
        end
        i_set_hit  = 1'b0;
        i_set_data = '0;
        forever begin
            @(negedge clk);
            c_addr  = o_set_addr;
            c_wr    = o_set_wr;
            c_cl    = o_set_cl;
            c_wdata = o_set_data;
            @(posedge clk); #1;
            c_idx = int'(c_addr % SZ);
            if (c_cl === 1'b1)
                s_valid[c_idx] = 1'b0;
            if (c_wr === 1'b1) begin
                s_valid[c_idx] = 1'b1;
                s_tag[c_idx]   = c_addr / SZ;
                s_data[c_idx]  = c_wdata;
            end
            i_set_hit  = s_valid[c_idx] && (s_tag[c_idx] == c_addr / SZ);
            i_set_data = s_data[c_idx];
        end
    end

    // Reference cache contents and statistics since the last sweep.
    logic          r_valid [SZ];
    logic [AW-1:0] r_tag   [SZ];
    logic [DW-1:0] r_data  [SZ];
    int            ref_hits;
    int            ref_misses;

    task automatic ref_clear();
        for (int i = 0; i < SZ; i++) begin
            r_valid[i] = 1'b0;
            r_tag[i]   = '0;
            r_data[i]  = '0;
        end
        ref_hits   = 0;
        ref_misses = 0;
    endtask

    // Entered at posedge+1 of the request cycle with i_req high; leaves at posedge+1 in IDLE.
    task automatic await_ack(input logic [AW-1:0] addr, input int exp_lat,
                             input logic [DW-1:0] exp_data, input int exp_mem, input string name);
        int            c;
        int            mem_cycles;
        int            wr_cycles;
        bit            acked;
        bit            bad_mem_addr;
        bit            both_wr_cl;
        logic          busy0;
        logic [DW-1:0] wr_data;
        mem_cycles = 0; wr_cycles = 0; acked = 1'b0; bad_mem_addr = 1'b0;
        both_wr_cl = 1'b0; wr_data = '0; busy0 = 1'b1;
        for (c = 0; c < 200; c++) begin
            @(negedge clk);
            if (c == 0) busy0 = o_busy;
            if (o_mem_rd === 1'b1) begin
                mem_cycles++;
                if (o_mem_addr !== addr) bad_mem_addr = 1'b1;
            end
            if (o_set_wr === 1'b1) begin
                wr_cycles++;
                wr_data = o_set_data;
            end
            if (o_set_wr === 1'b1 && o_set_cl === 1'b1) both_wr_cl = 1'b1;
            if (o_ack === 1'b1) begin
                acked = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (busy0 !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle_at_request: o_busy=%b expected 0", name, busy0);
        end
        vectors++;
        if (acked !== 1'b1) begin
            miscompares++;
            $display("FAIL %s ack_timeout: no o_ack within 200 cycles, expected at %0d", name, exp_lat);
        end
        vectors++;
        if (c !== exp_lat) begin
            miscompares++;
            $display("FAIL %s latency: got %0d cycles expected %0d", name, c, exp_lat);
        end
        vectors++;
        if (o_data !== exp_data) begin
            miscompares++;
            $display("FAIL %s ack_data: got %h expected %h", name, o_data, exp_data);
        end
        vectors++;
        if (mem_cycles !== exp_mem || bad_mem_addr) begin
            miscompares++;
            $display("FAIL %s mem_read: %0d cycles (bad_addr=%b) expected %0d cycles at %h",
                     name, mem_cycles, bad_mem_addr, exp_mem, addr);
        end
        vectors++;
        if (wr_cycles !== ((exp_mem > 0) ? 1 : 0) || both_wr_cl) begin
            miscompares++;
            $display("FAIL %s set_write: %0d cycles (wr&cl=%b) expected %0d", name, wr_cycles,
                     both_wr_cl, (exp_mem > 0) ? 1 : 0);
        end
        if (exp_mem > 0) begin
            vectors++;
            if (wr_data !== exp_data) begin
                miscompares++;
                $display("FAIL %s fill_data: got %h expected %h", name, wr_data, exp_data);
            end
        end
        @(posedge clk); #1;
        i_req = 1'b0;
        @(negedge clk);
        vectors++;
        if (o_ack !== 1'b0 || o_data !== exp_data) begin
            miscompares++;
            $display("FAIL %s data_hold: ack=%b data=%h expected ack=0 data=%h", name, o_ack,
                     o_data, exp_data);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int lat, input logic [DW-1:0] data,
                           input string name);
        int idx;
        bit hit;
        idx = int'(addr % SZ);
        hit = r_valid[idx] && (r_tag[idx] == addr / SZ);
        mem_lat   = lat;
        mem_value = data;
        i_addr    = addr;
        i_req     = 1'b1;
        if (hit) begin
            ref_hits++;
            await_ack(addr, 1, r_data[idx], 0, name);
        end else begin
            ref_misses++;
            await_ack(addr, 3 + lat, data, lat, name);
            r_valid[idx] = 1'b1;
            r_tag[idx]   = addr / SZ;
            r_data[idx]  = data;
        end
    endtask

    // Entered at posedge+1 of the first INIT cycle; leaves at posedge+1 of the IDLE cycle.
    task automatic check_sweep(input string name);
        for (int k = 0; k < SZ; k++) begin
            @(negedge clk);
            vectors++;
            if (o_set_cl !== 1'b1 || o_set_addr !== 32'(k) || o_ack !== 1'b0 || o_busy !== 1'b1) begin
                miscompares++;
                $display("FAIL %s[%0d]: cl=%b addr=%h ack=%b busy=%b expected cl=1 addr=%h ack=0 busy=1",
                         name, k, o_set_cl, o_set_addr, o_ack, o_busy, 32'(k));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic check_stats(input string name);
`ifdef ICACHE_CTRL_STATS_EN
        vectors++;
        if (o_hit_count !== 32'(ref_hits) || o_miss_count !== 32'(ref_misses)) begin
            miscompares++;
            $display("FAIL %s stats: hits=%0d misses=%0d expected hits=%0d misses=%0d", name,
                     o_hit_count, o_miss_count, ref_hits, ref_misses);
        end
`else
        if (name.len() == 0) $display("%s", name);
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; i_req = 1'b0; i_addr = '0; i_flush = 1'b0;
        mem_lat = 1; mem_value = '0;
        ref_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (o_busy !== 1'b1 || o_set_cl !== 1'b1 || o_ack !== 1'b0 || o_mem_rd !== 1'b0 ||
            o_set_wr !== 1'b0 || o_data !== '0 || o_mem_addr !== '0 || o_set_data !== '0 ||
            o_set_addr !== '0) begin
            miscompares++;
            $display("FAIL reset_values: busy=%b cl=%b ack=%b rd=%b wr=%b data=%h maddr=%h sdata=%h saddr=%h expected 1 1 0 0 0 and zeros",
                     o_busy, o_set_cl, o_ack, o_mem_rd, o_set_wr, o_data, o_mem_addr,
                     o_set_data, o_set_addr);
        end
        @(posedge clk); #1;
        rst    = 1'b0;
        i_addr = 32'h10;
        i_req  = 1'b1;
        check_sweep("reset_sweep");
        do_read(32'h10, 2, $urandom, "req_during_sweep");
    endtask

    task automatic test_cold_miss();
        do_read(32'h40, 3, 32'hDEADBEEF, "cold_miss");
    endtask

    task automatic test_hit();
        do_read(32'h40, 3, 32'h0BAD_F00D, "repeat_hit");
    endtask

    task automatic test_conflict();
        do_read(32'h48, $urandom_range(1, 4), 32'h12345678, "conflict_fill");
        do_read(32'h40, $urandom_range(1, 4), 32'hDEADBEEF, "conflict_remiss");
        do_read(32'h40, 2, 32'h0, "conflict_rehit");
    endtask

    task automatic test_flush();
        i_flush = 1'b1;
        i_addr  = 32'h40;
        i_req   = 1'b1;
        @(negedge clk);
        vectors++;
        if (o_ack !== 1'b0 || o_busy !== 1'b0 || o_set_cl !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_idle: ack=%b busy=%b cl=%b expected 0 0 0", o_ack, o_busy, o_set_cl);
        end
        @(posedge clk); #1;
        i_flush = 1'b0;
        ref_clear();
        check_sweep("flush_sweep");
        do_read(32'h40, 2, 32'hCAFEF00D, "flush_then_req");
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        for (int n = 0; n < 40; n++) begin
            a = AW'(($urandom_range(0, 3) << 3) | $urandom_range(0, 3));
            do_read(a, $urandom_range(1, 4), $urandom, "random_read");
        end
        check_stats("after_random");
    endtask

    task automatic test_reset_mid_fill();
        bit seen;
        seen      = 1'b0;
        mem_lat   = 50;
        mem_value = 32'h5555AAAA;
        i_addr    = 32'h1F8;
        i_req     = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (o_mem_rd === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL midfill_reach_fill: o_mem_rd=%b expected 1 within 20 cycles", o_mem_rd);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (o_mem_rd !== 1'b0 || o_ack !== 1'b0 || o_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL midfill_async_reset: rd=%b ack=%b busy=%b expected 0 0 1", o_mem_rd,
                     o_ack, o_busy);
        end
        i_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        ref_clear();
        check_sweep("midfill_sweep");
        check_stats("after_midfill_reset");
        do_read(32'h1F8, 2, $urandom, "after_reset_read");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush();
        test_random();
        test_reset_mid_fill();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/icache_controller.md
Name: icache_controller

Overview:
- Sequencing controller for one direct-mapped cache set (data/tag/valid memories, SIZE entries).
- Sits between the instruction-fetch requester and the backing memory port.
- Services lookups; on a miss, fetches the word from memory, writes it into the set, then returns it.
- Runs an invalidation sweep of every entry after reset and on flush request.

Parameters:
- DATA_WIDTH, 32, data word width in bits.
- ADDR_WIDTH, 32, word address width in bits.
- SIZE, 128, number of cache entries; power of two, ≥2. INDEX_WIDTH = $clog2(SIZE).

Ports:
- i_clock  in  1  clock; all state changes on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request; held with i_addr stable until o_ack.
- i_addr  in  ADDR_WIDTH  fetch word address.
- i_flush  in  1  request a full invalidation sweep (level, sampled in IDLE).
- o_ack  out  1  one-cycle pulse: o_data valid, request done.
- o_data  out  DATA_WIDTH  fetched word.
- o_busy  out  1  high in any state except IDLE.
- o_mem_addr  out  ADDR_WIDTH  backing-memory address.
- o_mem_rd  out  1  memory read request; held until i_mem_ack.
- i_mem_data  in  DATA_WIDTH  memory read data, valid with i_mem_ack.
- i_mem_ack  in  1  memory read complete.
- o_set_addr  out  ADDR_WIDTH  address to the cache set.
- o_set_wr  out  1  set write (fill).
- o_set_cl  out  1  set invalidate of entry at o_set_addr.
- o_set_data  out  DATA_WIDTH  fill data to the set.
- i_set_data  in  DATA_WIDTH  set read data, valid 1 cycle after address.
- i_set_hit  in  1  set hit, valid 1 cycle after address.

Behaviour:
- States: INIT, IDLE, LOOKUP, FILL, WRITE, RESPOND.
- Reset (async) values:
  - state = INIT; sweep index = 0.
  - o_ack, o_mem_rd, o_set_wr = 0; o_set_cl = 1 (INIT drives it).
  - o_data, o_mem_addr, o_set_data, latched addr = 0.
  - o_busy = 1.
- INIT:
  - o_set_cl = 1; o_set_addr = sweep index zero-extended.
  - Index increments each cycle. After index SIZE-1 is cleared, go to IDLE.
  - The sweep lasts exactly SIZE cycles; requests are ignored during it.
- IDLE:
  - i_flush has priority: index ← 0, go to INIT.
  - Else on i_req: latch i_addr, go to LOOKUP. o_set_addr = i_addr (combinational) so the set read starts this cycle.
- LOOKUP:
  - o_set_addr = latched addr.
  - i_set_hit = 1: o_ack = 1, o_data = i_set_data, go to IDLE. Hit latency is 1 cycle after the request cycle.
  - Else: go to FILL.
- FILL:
  - o_mem_rd = 1, o_mem_addr = latched addr.
  - On i_mem_ack: capture i_mem_data into the fill register, go to WRITE.
  - Memory latency is unbounded; o_mem_rd stays high until ack.
- WRITE:
  - One cycle: o_set_wr = 1, o_set_addr = latched addr, o_set_data = fill register. Go to RESPOND.
- RESPOND:
  - o_ack = 1, o_data = fill register; go to IDLE.
  - No re-lookup after a fill.
  - Miss latency = 1 + N_mem + 2 cycles after the request cycle, where N_mem = cycles to i_mem_ack including the ack cycle.
- o_set_wr and o_set_cl are never asserted together.
- o_data holds its last value when o_ack = 0.
- i_flush asserted outside IDLE: ignored until IDLE is reached. A level still high in IDLE starts a sweep before any new request.
- i_req dropped before o_ack: protocol violation; behaviour undefined, except that a transaction in FILL completes to memory.
- Reset during FILL: o_mem_rd drops immediately (async); the memory side must tolerate an abandoned read.

Optional Feature:
- Macro ICACHE_CTRL_STATS_EN.
- Defined: adds two ports, o_hit_count and o_miss_count, each 32 bits.
  - Counters zero on reset and on each INIT entry.
  - Hit counter increments in a LOOKUP hit cycle; miss counter increments in a LOOKUP miss cycle.
  - Both saturate at 2^32-1.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release with SIZE=8: o_set_cl high for 8 cycles, o_set_addr 0..7 in order; then o_busy=0. An i_req during the sweep gets no o_ack until after IDLE.
- Cold read 0x40, memory returns 0xDEADBEEF with 3-cycle latency:
  - o_mem_rd for 3 cycles at 0x40, then one o_set_wr cycle with 0xDEADBEEF.
  - o_ack with 0xDEADBEEF 6 cycles after the request cycle.
- Repeat read 0x40 (set model reports hit): o_ack with 0xDEADBEEF 1 cycle after the request; o_mem_rd never asserted.
- Conflict: read 0x48 (same index as 0x40 with SIZE=8, different tag): miss and fill with 0x12345678. A following read of 0x40 misses again.
- i_flush and i_req both high in IDLE: sweep runs first (8 cycles); then the request is serviced as a miss.
- Async reset asserted mid-FILL: o_mem_rd and o_ack go low without a clock edge; after release, INIT sweep restarts at index 0. With ICACHE_CTRL_STATS_EN defined, both counters read 0.
